// File: rtl/cmp_feed_pkg.sv
// Shared types and constants for the byte-serial comparator operand feeder.
package cmp_feed_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int BYTE_W    = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EVAL   = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/cmp_byte_feeder_operand_byte_reg.sv
// WIDTH-bit operand register written one byte at a time at a byte index.
module operand_byte_reg
  import cmp_feed_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  sel_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [WIDTH-1:0]  q_o
);

  localparam int NBYTES = WIDTH / BYTE_W;

  logic [WIDTH-1:0] q_q;

  // Byte-lane write; lanes not selected keep their contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (we_i) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (sel_i == IDX_W'(k)) begin
          q_q[k*BYTE_W +: BYTE_W] <= data_i;
        end
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/cmp_byte_feeder.sv
// Loads an operand pair from a byte stream, holds it for the external
// comparator, and returns the sampled result on a valid/ready output.
module cmp_byte_feeder
  import cmp_feed_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic [WIDTH-1:0]  op_a,
  output logic [WIDTH-1:0]  op_b,
  input  logic              lteq_i,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_lteq,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic             res_lteq_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;

  logic accept;
  logic we_a;
  logic we_b;
  logic last_byte;

  assign accept     = in_valid & in_ready_q;
  assign we_a       = accept & (state_q == LOAD_A);
  assign we_b       = accept & (state_q == LOAD_B);
  assign last_byte  = (cnt_q == LAST_IDX);
  assign drop_cnt_d = (drop_cnt_q == {CNT_W{1'b1}}) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);

  operand_byte_reg #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_reg_a (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_a),
    .sel_i  (cnt_q),
    .data_i (in_data),
    .q_o    (op_a)
  );

  operand_byte_reg #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_reg_b (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_b),
    .sel_i  (cnt_q),
    .data_i (in_data),
    .q_o    (op_b)
  );

  // Frame FSM: byte counter, framing checks, result capture and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_lteq_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state_q)
        LOAD_A: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (in_last) begin
              cnt_q       <= '0;
              err_pulse_q <= 1'b1;
              drop_cnt_q  <= drop_cnt_d;
            end else if (last_byte) begin
              state_q <= LOAD_B;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (last_byte && in_last) begin
              state_q    <= EVAL;
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
            end else if (last_byte || in_last) begin
              state_q     <= LOAD_A;
              cnt_q       <= '0;
              err_pulse_q <= 1'b1;
              drop_cnt_q  <= drop_cnt_d;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        EVAL: begin
          // Operands have been stable for a full period by this edge.
          res_lteq_q <= lteq_i;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= LOAD_A;
          end else begin
            res_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= LOAD_A;
          cnt_q       <= '0;
          in_ready_q  <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_lteq  = res_lteq_q;
  assign err_pulse = err_pulse_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cmp_byte_feeder.sv
// Randomized self-checking bench for cmp_byte_feeder with a behavioural comparator.
module tb_cmp_byte_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        lteq_i;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_lteq;
  logic        err_pulse;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int res_seen = 0;
  int exp_drop = 0;

  cmp_byte_feeder #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .op_a(op_a), .op_b(op_b),
    .lteq_i(lteq_i), .res_valid(res_valid), .res_ready(res_ready),
    .res_lteq(res_lteq), .err_pulse(err_pulse), .drop_cnt(drop_cnt)
  );

  assign lteq_i = (op_a <= op_b);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_pulse) err_seen++;
    if (res_valid && res_ready) res_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL wait_in_ready: in_ready=%b required 1 within 50 cycles", in_ready);
    end
  endtask

  // Sends bytes 0..nbytes-1 of the frame {B,A}; in_last marks byte last_pos.
  task automatic send_bytes(input logic [31:0] a, input logic [31:0] b,
                            input int nbytes, input int last_pos, input bit gaps);
    logic [63:0] frame;
    frame = {b, a};
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      wait_ready();
      in_valid = 1'b1;
      in_data  = frame[i*8 +: 8];
      in_last  = (i == last_pos);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({in_ready, res_valid, res_lteq, err_pulse} !== 4'b0000 || op_a !== 32'd0 ||
        op_b !== 32'd0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b rv=%b rl=%b err=%b a=%h b=%h drop=%0d required all zero",
               in_ready, res_valid, res_lteq, err_pulse, op_a, op_b, drop_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
    exp_drop = 0;
  endtask

  task automatic test_basic();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    ta[0] = 32'h00000005; tb[0] = 32'h00000007;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF;
    ta[2] = 32'h80000000; tb[2] = 32'h7FFFFFFF;
    for (int k = 0; k < 3; k++) begin
      send_bytes(ta[k], tb[k], 8, 7, 1'b0);
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL basic_eval[%0d]: rv=%b rdy=%b required 0 0", k, res_valid, in_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_latency_early[%0d]: res_valid=%b required 0", k, res_valid);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_lteq !== (ta[k] <= tb[k]) || op_a !== ta[k] || op_b !== tb[k]) begin
        failures++;
        $display("FAIL basic_result[%0d]: rv=%b lteq=%b a=%h b=%h required 1 %b %h %h",
                 k, res_valid, res_lteq, op_a, op_b, ta[k] <= tb[k], ta[k], tb[k]);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL basic_handshake[%0d]: rv=%b rdy=%b required 0 1", k, res_valid, in_ready);
      end
    end
  endtask

  task automatic test_drop_then_frame();
    int err0;
    int res0;
    err0 = err_seen;
    res0 = res_seen;
    res_ready = 1'b1;
    send_bytes(32'h11223344, 32'h55667788, 4, 3, 1'b0);
    exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    checks++;
    if (err_pulse !== 1'b1 || drop_cnt !== 8'(exp_drop) || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drop_early_last: err=%b drop=%0d rdy=%b required 1 %0d 1", err_pulse, drop_cnt, in_ready, exp_drop);
    end
    tick();
    checks++;
    if (err_pulse !== 1'b0 || err_seen - err0 != 1 || res_valid !== 1'b0 || res_seen != res0) begin
      failures++;
      $display("FAIL drop_single_pulse: err=%b pulses=%0d rv=%b results=%0d required 0 1 0 0",
               err_pulse, err_seen - err0, res_valid, res_seen - res0);
    end
    res_ready = 1'b0;
    send_bytes(32'd1, 32'd0, 8, 7, 1'b0);
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_lteq !== 1'b0) begin
      failures++;
      $display("FAIL drop_next_frame: rv=%b lteq=%b required 1 0", res_valid, res_lteq);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic exp_l;
    send_bytes(32'h00000100, 32'h000000FF, 8, 7, 1'b0);
    exp_l = (32'h00000100 <= 32'h000000FF);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (res_valid !== 1'b1 || res_lteq !== exp_l || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: rv=%b lteq=%b rdy=%b required 1 %b 0", c, res_valid, res_lteq, in_ready, exp_l);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_lteq !== exp_l) begin
      failures++;
      $display("FAIL hold_release: rv=%b rdy=%b lteq=%b required 0 1 %b", res_valid, in_ready, res_lteq, exp_l);
    end
  endtask

  task automatic test_reset_midframe();
    int err0;
    int res0;
    err0 = err_seen;
    res0 = res_seen;
    res_ready = 1'b1;
    send_bytes(32'hDEADBEEF, 32'h0BADF00D, 6, 99, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_drop = 0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL midframe_reset: rv=%b rdy=%b drop=%0d required 0 0 0", res_valid, in_ready, drop_cnt);
    end
    res_ready = 1'b0;
    send_bytes(32'd3, 32'd3, 8, 7, 1'b0);
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_lteq !== 1'b1 || err_seen != err0 || res_seen != res0) begin
      failures++;
      $display("FAIL midframe_next: rv=%b lteq=%b pulses=%0d results=%0d required 1 1 0 0",
               res_valid, res_lteq, err_seen - err0, res_seen - res0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    int kind;
    int res0;
    for (int f = 0; f < 40; f++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 1) == 0) a = a >> $urandom_range(0, 31);
      kind = $urandom_range(0, 4);
      res0 = res_seen;
      if (kind == 0) begin
        send_bytes(a, b, 8, 99, 1'b1);
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        checks++;
        if (err_pulse !== 1'b1 || drop_cnt !== 8'(exp_drop) || res_seen != res0) begin
          failures++;
          $display("FAIL rand_missing_last[%0d]: err=%b drop=%0d required 1 %0d", f, err_pulse, drop_cnt, exp_drop);
        end
      end else if (kind == 1) begin
        int lp;
        lp = $urandom_range(0, 6);
        send_bytes(a, b, lp + 1, lp, 1'b1);
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        checks++;
        if (err_pulse !== 1'b1 || drop_cnt !== 8'(exp_drop) || res_seen != res0) begin
          failures++;
          $display("FAIL rand_early_last[%0d]: byte=%0d err=%b drop=%0d required 1 %0d", f, lp, err_pulse, drop_cnt, exp_drop);
        end
      end else begin
        send_bytes(a, b, 8, 7, 1'b1);
        tick();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_lteq !== (a <= b)) begin
          failures++;
          $display("FAIL rand_result[%0d]: a=%h b=%h rv=%b lteq=%b required 1 %b", f, a, b, res_valid, res_lteq, a <= b);
        end
        repeat ($urandom_range(0, 2)) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
      end
    end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 300; f++) begin
      send_bytes(32'hA5A5A5A5, 32'h5A5A5A5A, 1, 0, 1'b0);
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      checks++;
      if (err_pulse !== 1'b1 || drop_cnt !== 8'(exp_drop)) begin
        failures++;
        $display("FAIL saturate[%0d]: err=%b drop=%0d required 1 %0d", f, err_pulse, drop_cnt, exp_drop);
      end
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("FAIL saturate_final: drop=%0d required 255", drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop_then_frame();
    test_hold();
    test_reset_midframe();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
